// File: rtl/led_pwm_driver_if.sv
// IO-bus side of the LED PWM driver: LED word, brightness register write port, pin drive.
interface led_pwm_driver_if;
  logic [23:0] leds_in;
  logic        brightCtrl;
  logic        ioWrite;
  logic [15:0] write_data;
  logic [23:0] led_pins;
  logic        period_start;

  modport master (
    output leds_in, brightCtrl, ioWrite, write_data,
    input  led_pins, period_start
  );

  modport slave (
    input  leds_in, brightCtrl, ioWrite, write_data,
    output led_pins, period_start
  );
endinterface

// File: rtl/led_pwm_driver.sv
// Drives the board LED pins with global PWM brightness and optional blink; brightness/blink
// settings are double-buffered and only take effect at PWM period boundaries.
module led_pwm_driver #(
  parameter int unsigned PWM_BITS      = 8,
  parameter int unsigned PRESCALE      = 100,
  parameter int unsigned BLINK_PERIODS = 256
) (
  input  logic             clock,
  input  logic             reset,
  led_pwm_driver_if.slave  bus
);

  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned BL_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam logic [PS_W-1:0]     PS_MAX  = PS_W'(PRESCALE - 1);
  localparam logic [BL_W-1:0]     BL_MAX  = BL_W'(BLINK_PERIODS - 1);
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  logic [PS_W-1:0]     prescaler;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [BL_W-1:0]     blink_cnt;
  logic                blink_phase;
  logic [PWM_BITS-1:0] pending_duty;
  logic [PWM_BITS-1:0] active_duty;
  logic                pending_blink;
  logic                active_blink;

  logic tick_c;
  logic boundary_c;
  logic write_c;
  logic pwm_on_c;
  logic blink_on_c;
  logic unused_c;

  // Timing strobes and the combined LED enable for the current cycle
  always_comb begin
    tick_c     = 1'b0;
    boundary_c = 1'b0;
    write_c    = 1'b0;
    pwm_on_c   = 1'b0;
    blink_on_c = 1'b1;
    tick_c     = (prescaler == PS_MAX);
    boundary_c = tick_c && (pwm_cnt == CNT_MAX);
    write_c    = bus.brightCtrl && bus.ioWrite;
    pwm_on_c   = (active_duty == CNT_MAX) ? 1'b1 : (pwm_cnt < active_duty);
    blink_on_c = active_blink ? blink_phase : 1'b1;
  end

  // Only duty bits and bit 8 of write_data carry meaning
  assign unused_c = ^bus.write_data;

  // Prescaler and PWM period counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      pwm_cnt   <= '0;
    end else begin
      prescaler <= tick_c ? '0 : prescaler + PS_W'(1);
      if (tick_c) pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // Blink phase toggles every BLINK_PERIODS boundaries, independent of blink enable
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (boundary_c) begin
      if (blink_cnt == BL_MAX) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BL_W'(1);
      end
    end
  end

  // Double-buffered settings: a write racing the boundary lands in pending only
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_duty  <= '1;
      pending_blink <= 1'b0;
      active_duty   <= '1;
      active_blink  <= 1'b0;
    end else begin
      if (write_c) begin
        pending_duty  <= bus.write_data[PWM_BITS-1:0];
        pending_blink <= bus.write_data[8];
      end
      if (boundary_c) begin
        active_duty  <= pending_duty;
        active_blink <= pending_blink;
      end
    end
  end

  // Registered pin drive and commit-point pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.led_pins     <= '0;
      bus.period_start <= 1'b0;
    end else begin
      bus.led_pins     <= bus.leds_in & {24{pwm_on_c & blink_on_c}};
      bus.period_start <= boundary_c;
    end
  end

endmodule
